// File: rtl/move_frame_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared constants and types for the move frame receiver:
//               board geometry, frame count codes and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    // Board geometry: valid coordinates are 0..BOARD_SIZE-1
    localparam int BOARD_SIZE = 19;
    localparam int COORD_W    = 6;

    // Leading count byte of a move frame
    localparam logic [7:0] CNT_FIRST = 8'h00;  // we move first, no stones
    localparam logic [7:0] CNT_ONE   = 8'h01;  // opening move, one stone
    localparam logic [7:0] CNT_TWO   = 8'h02;  // regular move, two stones

    // One byte of the incoming stream
    typedef logic [7:0] rx_byte_t;

    // Receiver FSM states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_X1  = 3'd1,
        GET_Y1  = 3'd2,
        GET_X2  = 3'd3,
        GET_Y2  = 3'd4,
        PLACE   = 3'd5,
        COMPUTE = 3'd6,
        ERROR   = 3'd7
    } state_e;

endpackage
`default_nettype wire

// File: rtl/move_frame_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : move_frame_receiver_if
// Description : Byte-stream valid/ready channel carrying opponent move frames.
// Revision    : 1.0 - initial release
// ============================================================================
interface move_frame_receiver_if;
    import game_pkg::*;

    rx_byte_t rx_data;
    logic     rx_valid;
    logic     rx_ready;

    // Byte source
    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    // Byte sink (the receiver)
    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface
`default_nettype wire

// File: rtl/move_frame_receiver_byte_timeout.sv
`default_nettype none
// ============================================================================
// Module      : byte_timeout
// Description : Inter-byte watchdog. Down-counter loaded with
//               TIMEOUT_CYCLES-1 on each accepted byte, decremented while
//               waiting, and flags expiry when it is waiting at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,    // byte accepted, restart the window
    input  logic clear,   // outside a frame, park at zero
    input  logic enable,  // waiting for a byte this cycle
    output logic expire   // window exhausted on this cycle
);

    localparam int c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_load_value = c_cnt_w'(TIMEOUT_CYCLES - 1);

    logic [c_cnt_w-1:0] r_count;

    // Load has priority so the window restarts even on the byte that opens a frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= c_load_value;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != '0)) begin
            r_count <= r_count - c_cnt_w'(1);
        end
    end

    assign expire = enable && (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/move_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : move_frame_receiver
// Description : Receives opponent move frames (count byte + count x/y pairs),
//               validates them, presents the stones to the board logic and
//               sequences compute_move until move_done.
// Revision    : 1.0 - initial release
// ============================================================================
module move_frame_receiver
    import game_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 rst,
    move_frame_receiver_if.slave rx,
    output logic [COORD_W-1:0]   x_1,
    output logic [COORD_W-1:0]   y_1,
    output logic [COORD_W-1:0]   x_2,
    output logic [COORD_W-1:0]   y_2,
    output logic [1:0]           stone_count,
    output logic                 place_strobe,
    output logic                 compute_move,
    input  logic                 move_done,
    output logic                 frame_error,
    output logic                 busy
);

    localparam logic [2:0] c_idle    = IDLE;
    localparam logic [2:0] c_get_x1  = GET_X1;
    localparam logic [2:0] c_get_y1  = GET_Y1;
    localparam logic [2:0] c_get_x2  = GET_X2;
    localparam logic [2:0] c_get_y2  = GET_Y2;
    localparam logic [2:0] c_place   = PLACE;
    localparam logic [2:0] c_compute = COMPUTE;
    localparam logic [2:0] c_error   = ERROR;

    localparam logic [7:0] c_board_limit = 8'(BOARD_SIZE);

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic               r_two;      // frame carries two stones
    logic [COORD_W-1:0] r_x1;
    logic [COORD_W-1:0] r_y1;
    logic [COORD_W-1:0] r_x2;

    logic               w_ready;
    logic               w_accept;
    logic               w_in_get;
    logic               w_next_is_get;
    logic               w_coord_bad;
    logic               w_dup;
    logic               w_expire;
    logic [COORD_W-1:0] w_coord;

    assign w_in_get      = (r_state == c_get_x1) || (r_state == c_get_y1) ||
                           (r_state == c_get_x2) || (r_state == c_get_y2);
    assign w_next_is_get = (w_next == c_get_x1) || (w_next == c_get_y1) ||
                           (w_next == c_get_x2) || (w_next == c_get_y2);
    assign w_ready       = (r_state == c_idle) || w_in_get;
    assign w_accept      = rx.rx_valid && w_ready;
    assign w_coord       = rx.rx_data[COORD_W-1:0];
    // Range check on the full byte so high bits cannot alias into range
    assign w_coord_bad   = (rx.rx_data >= c_board_limit);
    // Second stone on the same point as the first is illegal
    assign w_dup         = (r_x2 == r_x1) && (w_coord == r_y1);

    assign rx.rx_ready   = w_ready;
    assign place_strobe  = (r_state == c_place);
    assign compute_move  = (r_state == c_compute);
    assign frame_error   = (r_state == c_error);
    assign busy          = (r_state != c_idle);

    byte_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_byte_timeout (
        .clk    (clk),
        .rst    (rst),
        .load   (w_accept && w_next_is_get),
        .clear  (!w_in_get),
        .enable (w_in_get && !w_accept),
        .expire (w_expire)
    );

    // Next-state decode: frame parsing, validation and compute handshake
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle: begin
                if (w_accept) begin
                    if (rx.rx_data == CNT_FIRST) begin
                        w_next = c_compute;
                    end else if ((rx.rx_data == CNT_ONE) || (rx.rx_data == CNT_TWO)) begin
                        w_next = c_get_x1;
                    end else begin
                        w_next = c_error;
                    end
                end
            end
            c_get_x1: begin
                if (w_accept) begin
                    w_next = w_coord_bad ? c_error : c_get_y1;
                end else if (w_expire) begin
                    w_next = c_error;
                end
            end
            c_get_y1: begin
                if (w_accept) begin
                    if (w_coord_bad) begin
                        w_next = c_error;
                    end else begin
                        w_next = r_two ? c_get_x2 : c_place;
                    end
                end else if (w_expire) begin
                    w_next = c_error;
                end
            end
            c_get_x2: begin
                if (w_accept) begin
                    w_next = w_coord_bad ? c_error : c_get_y2;
                end else if (w_expire) begin
                    w_next = c_error;
                end
            end
            c_get_y2: begin
                if (w_accept) begin
                    w_next = (w_coord_bad || w_dup) ? c_error : c_place;
                end else if (w_expire) begin
                    w_next = c_error;
                end
            end
            c_place:   w_next = c_compute;
            c_compute: w_next = move_done ? c_idle : c_compute;
            c_error:   w_next = c_idle;
            default:   w_next = c_idle;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // Shadow registers collect the frame; an error discards them
    always_ff @(posedge clk) begin
        if (rst || (r_state == c_error)) begin
            r_two <= 1'b0;
            r_x1  <= '0;
            r_y1  <= '0;
            r_x2  <= '0;
        end else if (w_accept) begin
            case (r_state)
                c_idle:   r_two <= (rx.rx_data == CNT_TWO);
                c_get_x1: r_x1  <= w_coord;
                c_get_y1: r_y1  <= w_coord;
                c_get_x2: r_x2  <= w_coord;
                default:  ;
            endcase
        end
    end

    // Published coordinates change only when a frame completes
    always_ff @(posedge clk) begin
        if (rst) begin
            x_1         <= '0;
            y_1         <= '0;
            x_2         <= '0;
            y_2         <= '0;
            stone_count <= 2'd0;
        end else if ((r_state == c_get_y1) && (w_next == c_place)) begin
            x_1         <= r_x1;
            y_1         <= w_coord;
            x_2         <= r_x1;
            y_2         <= w_coord;
            stone_count <= 2'd1;
        end else if ((r_state == c_get_y2) && (w_next == c_place)) begin
            x_1         <= r_x1;
            y_1         <= r_y1;
            x_2         <= r_x2;
            y_2         <= w_coord;
            stone_count <= 2'd2;
        end else if ((r_state == c_idle) && (w_next == c_compute)) begin
            stone_count <= 2'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_move_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_move_frame_receiver
// Description : Directed self-checking bench for move_frame_receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_move_frame_receiver;
    import game_pkg::*;

    localparam int TIMEOUT = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               move_done = 1'b0;
    logic [COORD_W-1:0] x_1, y_1, x_2, y_2;
    logic [1:0]         stone_count;
    logic               place_strobe, compute_move, frame_error, busy;

    int checks  = 0;
    int errors  = 0;
    int n_place = 0;
    int n_err   = 0;

    move_frame_receiver_if rx_if ();

    move_frame_receiver #(
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx_if),
        .x_1          (x_1),
        .y_1          (y_1),
        .x_2          (x_2),
        .y_2          (y_2),
        .stone_count  (stone_count),
        .place_strobe (place_strobe),
        .compute_move (compute_move),
        .move_done    (move_done),
        .frame_error  (frame_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Pulse counters
    always @(posedge clk) begin
        if (place_strobe) n_place++;
        if (frame_error)  n_err++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_if.rx_data  = b;
        rx_if.rx_valid = 1'b1;
        @(posedge clk);
    endtask

    task automatic idle_bus();
        @(negedge clk);
        rx_if.rx_valid = 1'b0;
    endtask

    initial begin
        rx_if.rx_data  = 8'h00;
        rx_if.rx_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rx_ready", rx_if.rx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_place", place_strobe, 0);
        check("rst_compute", compute_move, 0);
        check("rst_error", frame_error, 0);
        check("rst_x1", x_1, 0);
        check("rst_count", stone_count, 0);
        rst = 1'b0;

        // Two-stone frame, back to back
        send(8'h02); send(8'h03); send(8'h04); send(8'h0A); send(8'h0B);
        idle_bus();
        check("t1_place", place_strobe, 1);
        check("t1_x1", x_1, 3);
        check("t1_y1", y_1, 4);
        check("t1_x2", x_2, 10);
        check("t1_y2", y_2, 11);
        check("t1_count", stone_count, 2);
        check("t1_compute_n1", compute_move, 0);
        check("t1_rx_ready", rx_if.rx_ready, 0);
        @(negedge clk);
        check("t1_compute_n2", compute_move, 1);
        check("t1_place_off", place_strobe, 0);
        repeat (3) @(negedge clk);
        check("t1_compute_hold", compute_move, 1);
        move_done = 1'b1;
        @(negedge clk);
        move_done = 1'b0;
        check("t1_compute_done", compute_move, 0);
        check("t1_busy_done", busy, 0);
        check("t1_ready_done", rx_if.rx_ready, 1);
        check("t1_place_cnt", n_place, 1);

        // One-stone frame
        send(8'h01); send(8'h09); send(8'h09);
        idle_bus();
        check("t2_place", place_strobe, 1);
        check("t2_x1", x_1, 9);
        check("t2_y1", y_1, 9);
        check("t2_x2", x_2, 9);
        check("t2_y2", y_2, 9);
        check("t2_count", stone_count, 1);
        @(negedge clk);
        check("t2_compute", compute_move, 1);
        move_done = 1'b1;
        @(negedge clk);
        move_done = 1'b0;
        check("t2_compute_done", compute_move, 0);
        check("t2_place_cnt", n_place, 2);

        // Out-of-range coordinate (19)
        send(8'h02); send(8'h05); send(8'h13);
        idle_bus();
        check("t4_error", frame_error, 1);
        check("t4_place", place_strobe, 0);
        check("t4_x1_kept", x_1, 9);
        check("t4_y2_kept", y_2, 9);
        check("t4_count_kept", stone_count, 1);
        @(negedge clk);
        check("t4_error_pulse", frame_error, 0);
        check("t4_busy", busy, 0);
        check("t4_compute", compute_move, 0);
        check("t4_err_cnt", n_err, 1);

        // Valid frame after error, boundary coordinates 0 and 18
        send(8'h01); send(8'h00); send(8'h12);
        idle_bus();
        check("t4b_place", place_strobe, 1);
        check("t4b_x1", x_1, 0);
        check("t4b_y1", y_1, 18);
        check("t4b_y2", y_2, 18);
        @(negedge clk);
        check("t4b_compute", compute_move, 1);
        move_done = 1'b1;
        @(negedge clk);
        move_done = 1'b0;
        check("t4b_compute_done", compute_move, 0);

        // Invalid count byte
        send(8'h03);
        idle_bus();
        check("bad_count_error", frame_error, 1);
        @(negedge clk);
        check("bad_count_busy", busy, 0);
        check("bad_count_err_cnt", n_err, 2);

        // Duplicate stone
        send(8'h02); send(8'h01); send(8'h01); send(8'h01); send(8'h01);
        idle_bus();
        check("t5_error", frame_error, 1);
        check("t5_count_kept", stone_count, 1);
        @(negedge clk);
        check("t5_compute", compute_move, 0);
        check("t5_busy", busy, 0);
        check("t5_place_cnt", n_place, 3);

        // Count 0: compute immediately, no stones
        send(8'h00);
        idle_bus();
        check("t3_compute", compute_move, 1);
        check("t3_place", place_strobe, 0);
        check("t3_count", stone_count, 0);
        @(negedge clk);
        check("t3_compute_hold", compute_move, 1);
        move_done = 1'b1;
        @(negedge clk);
        move_done = 1'b0;
        check("t3_compute_done", compute_move, 0);
        check("t3_place_cnt", n_place, 3);

        // move_done already high on entry: one-cycle compute_move
        move_done = 1'b1;
        send(8'h00);
        idle_bus();
        check("md_early_compute", compute_move, 1);
        @(negedge clk);
        check("md_early_done", compute_move, 0);
        check("md_early_busy", busy, 0);
        move_done = 1'b0;

        // Byte held during COMPUTE is consumed once IDLE returns
        send(8'h00);
        @(negedge clk);
        rx_if.rx_data  = 8'h01;
        rx_if.rx_valid = 1'b1;
        check("hold_compute", compute_move, 1);
        check("hold_ready", rx_if.rx_ready, 0);
        @(negedge clk);
        check("hold_busy", busy, 1);
        move_done = 1'b1;
        @(negedge clk);
        move_done = 1'b0;
        check("hold_idle_compute", compute_move, 0);
        check("hold_idle_ready", rx_if.rx_ready, 1);
        send(8'h02); send(8'h03);
        idle_bus();
        check("hold_place", place_strobe, 1);
        check("hold_x1", x_1, 2);
        check("hold_y1", y_1, 3);
        check("hold_count", stone_count, 1);

        // Reset mid-compute
        @(negedge clk);
        check("rst2_compute_pre", compute_move, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst2_compute", compute_move, 0);
        check("rst2_ready", rx_if.rx_ready, 1);
        check("rst2_busy", busy, 0);
        check("rst2_x1", x_1, 0);
        check("rst2_y1", y_1, 0);
        check("rst2_count", stone_count, 0);
        check("rst2_error", frame_error, 0);
        check("rst2_err_cnt", n_err, 3);
        rst = 1'b0;

        // Inter-byte timeout
        send(8'h02); send(8'h07);
        idle_bus();
        repeat (15) @(negedge clk);
        check("to_no_error_yet", frame_error, 0);
        check("to_busy", busy, 1);
        check("to_err_cnt_pre", n_err, 3);
        @(negedge clk);
        check("to_error", frame_error, 1);
        @(negedge clk);
        check("to_idle", busy, 0);
        check("to_err_cnt", n_err, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
